// File: rtl/risc_local_ram_if.sv
// ---------------------------------------------------------------------------
// risc_local_ram_if
// Bus bundle for the RISC local RAM. Port A is the core execution side and
// port B is the system-bus/blitter side.
//   master modport : requester side (drives req/we/be/addr/wdata, sees results)
//   slave modport  : RAM side (sees requests, drives ready/rdata/rvalid/oe/par_err)
// Signals per port x in {a,b}:
//   x_req, x_we, x_be[DATA_W/8], x_addr[ADDR_W], x_wdata[DATA_W]  (to RAM)
//   x_ready, x_rdata[DATA_W], x_rvalid                           (from RAM)
// Shared: b_oe[DATA_W] bus drive mask, par_err sticky parity error.
// ---------------------------------------------------------------------------
interface risc_local_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  a_req;
    logic                  a_we;
    logic [DATA_W/8-1:0]   a_be;
    logic [ADDR_W-1:0]     a_addr;
    logic [DATA_W-1:0]     a_wdata;
    logic                  a_ready;
    logic [DATA_W-1:0]     a_rdata;
    logic                  a_rvalid;

    logic                  b_req;
    logic                  b_we;
    logic [DATA_W/8-1:0]   b_be;
    logic [ADDR_W-1:0]     b_addr;
    logic [DATA_W-1:0]     b_wdata;
    logic                  b_ready;
    logic [DATA_W-1:0]     b_rdata;
    logic                  b_rvalid;

    logic [DATA_W-1:0]     b_oe;
    logic                  par_err;

    modport master (
        output a_req, a_we, a_be, a_addr, a_wdata,
        input  a_ready, a_rdata, a_rvalid,
        output b_req, b_we, b_be, b_addr, b_wdata,
        input  b_ready, b_rdata, b_rvalid,
        input  b_oe, par_err
    );

    modport slave (
        input  a_req, a_we, a_be, a_addr, a_wdata,
        output a_ready, a_rdata, a_rvalid,
        input  b_req, b_we, b_be, b_addr, b_wdata,
        output b_ready, b_rdata, b_rvalid,
        output b_oe, par_err
    );
endinterface

// File: rtl/risc_local_ram.sv
// ---------------------------------------------------------------------------
// risc_local_ram
// Dual-port local RAM for the GPU/DSP RISC cores, built on one single-ported
// synchronous array. A fixed-priority arbiter grants port A first, except
// when port B has stalled STARVE_MAX consecutive cycles, which forces a B
// grant. Writes are byte-enabled; reads have one cycle of latency with a
// one-cycle valid pulse per port. b_oe is the bus drive mask for port B.
//
// Ports:
//   clk     in  system clock, rising edge
//   resetl  in  asynchronous active-low reset (array contents are kept)
//   bus     slave modport of risc_local_ram_if (A/B request, response,
//           b_oe, par_err)
//
// Optional feature: define RISC_RAM_PARITY_EN to store an even-parity bit per
// byte and flag (sticky par_err) any mismatch seen on a granted read. Without
// it, no parity is stored and par_err is tied 0.
// ---------------------------------------------------------------------------
module risc_local_ram #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             resetl,
    risc_local_ram_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [3:0]        starve_q, starve_d;
    logic              force_b, a_gnt, b_gnt;

    logic              sel_we;
    logic [NB-1:0]     sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              wr_en, rd_en;
    logic [DATA_W-1:0] rd_word;

    logic              a_rvalid_q, b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    // Arbitration: A has priority unless B has waited long enough.
    assign force_b = (starve_q == 4'(STARVE_MAX));
    assign b_gnt   = bus.b_req & (force_b | ~bus.a_req);
    assign a_gnt   = bus.a_req & ~b_gnt;

    assign bus.a_ready = a_gnt;
    assign bus.b_ready = b_gnt;

    // Steer the granted port onto the single array port.
    always_comb begin
        sel_we    = bus.a_we;
        sel_be    = bus.a_be;
        sel_addr  = bus.a_addr;
        sel_wdata = bus.a_wdata;
        if (b_gnt) begin
            sel_we    = bus.b_we;
            sel_be    = bus.b_be;
            sel_addr  = bus.b_addr;
            sel_wdata = bus.b_wdata;
        end
    end

    assign wr_en   = (a_gnt | b_gnt) & sel_we;
    assign rd_en   = (a_gnt | b_gnt) & ~sel_we;
    assign rd_word = mem_q[sel_addr];

    // Starvation counter: counts B stall cycles, cleared by a grant or idle B.
    always_comb begin
        starve_d = 4'd0;
        if (bus.b_req & ~b_gnt) begin
            starve_d = force_b ? starve_q : starve_q + 4'd1;
        end
    end

`ifdef RISC_RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic          par_bad;
    logic          par_err_q;

    function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^w[i*8 +: 8];
        end
        return p;
    endfunction

    assign par_bad     = |(byte_parity(rd_word) ^ par_q[sel_addr]);
    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif

    // Array write; not reset, and suppressed on any edge where resetl is low.
    always_ff @(posedge clk) begin
        if (resetl && wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (sel_be[i]) begin
                    mem_q[sel_addr][i*8 +: 8] <= sel_wdata[i*8 +: 8];
`ifdef RISC_RAM_PARITY_EN
                    par_q[sel_addr][i] <= ^sel_wdata[i*8 +: 8];
`endif
                end
            end
        end
    end

    // Read response registers and control state.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            starve_q   <= 4'd0;
`ifdef RISC_RAM_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            a_rvalid_q <= a_gnt & ~bus.a_we;
            b_rvalid_q <= b_gnt & ~bus.b_we;
            if (a_gnt & ~bus.a_we) begin
                a_rdata_q <= rd_word;
            end
            if (b_gnt & ~bus.b_we) begin
                b_rdata_q <= rd_word;
            end
            starve_q <= starve_d;
`ifdef RISC_RAM_PARITY_EN
            if (rd_en & par_bad) begin
                par_err_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.a_rdata  = a_rdata_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.b_rvalid = b_rvalid_q;
    assign bus.b_oe     = {DATA_W{b_rvalid_q}};

    // rd_en is only consumed by the parity checker.
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
endmodule

// File: tb/tb_risc_local_ram.sv
// ---------------------------------------------------------------------------
// tb_risc_local_ram
// Directed and randomized checks of risc_local_ram against a word-level model
// (array of words, per-cycle grant rule, stall counter, expected responses).
// ---------------------------------------------------------------------------
module tb_risc_local_ram;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic resetl = 1'b0;
    always #5 clk = ~clk;

    risc_local_ram_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

    risc_local_ram #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SM)) dut (
        .clk    (clk),
        .resetl (resetl),
        .bus    (ifc.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] mem_m [1024];
    logic [3:0]    bad_m [1024];
    int            starve_m;
    logic [DW-1:0] ea_rd, eb_rd;
    logic          ea_v, eb_v, par_m;
    bit            last_ga, last_gb;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [AW-1:0] ad, input logic [3:0] be, input logic [DW-1:0] wd);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem_m[ad][i*8 +: 8] = wd[i*8 +: 8];
                bad_m[ad][i] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("a_rvalid", {31'b0, ifc.a_rvalid}, {31'b0, ea_v});
        chk("b_rvalid", {31'b0, ifc.b_rvalid}, {31'b0, eb_v});
        chk("a_rdata", ifc.a_rdata, ea_rd);
        chk("b_rdata", ifc.b_rdata, eb_rd);
        chk("b_oe", ifc.b_oe, eb_v ? 32'hFFFF_FFFF : 32'h0);
        chk("par_err", {31'b0, ifc.par_err}, {31'b0, par_m});
    endtask

    // One clock cycle: inputs are already driven (at posedge+1).
    task automatic step();
        bit ga, gb;
        #1;
        gb = ifc.b_req && ((starve_m == SM) || !ifc.a_req);
        ga = ifc.a_req && !gb;
        chk("a_ready", {31'b0, ifc.a_ready}, {31'b0, ga});
        chk("b_ready", {31'b0, ifc.b_ready}, {31'b0, gb});
        ea_v = ga && !ifc.a_we;
        eb_v = gb && !ifc.b_we;
        if (ga) begin
            if (ifc.a_we) model_write(ifc.a_addr, ifc.a_be, ifc.a_wdata);
            else begin
                ea_rd = mem_m[ifc.a_addr];
                if (|bad_m[ifc.a_addr]) par_m = 1'b1;
            end
        end
        if (gb) begin
            if (ifc.b_we) model_write(ifc.b_addr, ifc.b_be, ifc.b_wdata);
            else begin
                eb_rd = mem_m[ifc.b_addr];
                if (|bad_m[ifc.b_addr]) par_m = 1'b1;
            end
        end
        if (ifc.b_req && !gb) starve_m = (starve_m < SM) ? starve_m + 1 : SM;
        else starve_m = 0;
        last_ga = ga;
        last_gb = gb;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        ifc.a_req = 0; ifc.a_we = 0; ifc.a_be = 0; ifc.a_addr = 0; ifc.a_wdata = 0;
        ifc.b_req = 0; ifc.b_we = 0; ifc.b_be = 0; ifc.b_addr = 0; ifc.b_wdata = 0;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [3:0] be,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        ifc.a_req = req; ifc.a_we = we; ifc.a_be = be; ifc.a_addr = ad; ifc.a_wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [3:0] be,
                           input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        ifc.b_req = req; ifc.b_we = we; ifc.b_be = be; ifc.b_addr = ad; ifc.b_wdata = wd;
    endtask

    task automatic model_reset();
        starve_m = 0; ea_rd = 0; eb_rd = 0; ea_v = 0; eb_v = 0; par_m = 0;
    endtask

    // Reset with both ports requesting writes to 0x005; entered at posedge+1.
    task automatic do_reset();
        resetl = 1'b0;
        drive_a(1, 1, 4'hF, 10'h005, 32'hBAD0_BAD0);
        drive_b(1, 1, 4'hF, 10'h005, 32'h0BAD_0BAD);
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        idle_inputs();
        resetl = 1'b1;
    endtask

    logic [AW-1:0] pool [16];
    logic [10:0]   wide_addr;
    int            first_b;

    // Pending random transactions
    bit            pa, pb;
    logic          wa, wb;
    logic [3:0]    bea, beb;
    logic [AW-1:0] ada, adb;
    logic [DW-1:0] wda, wdb;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_m[i] = 'x;
            bad_m[i] = 4'h0;
        end
        idle_inputs();
        model_reset();

        // Power-on reset
        do_reset();

        // Known content at 0x005, then a read interrupted by reset
        drive_a(1, 1, 4'hF, 10'h005, 32'h1111_1111); step();
        drive_a(1, 0, 4'h0, 10'h005, 32'h0);          step();
        resetl = 1'b0;
        ea_v = 0; eb_v = 0;
        #1;
        chk("reset_drops_rvalid", {31'b0, ifc.a_rvalid}, 32'h0);
        @(posedge clk); #1;
        do_reset();

        // Writes presented during reset must not have landed
        drive_a(1, 0, 4'h0, 10'h005, 32'h0); step();
        chk("no_write_in_reset", ifc.a_rdata, 32'h1111_1111);

        // A write then A read, then idle
        drive_a(1, 1, 4'hF, 10'h005, 32'hDEAD_BEEF); step();
        drive_a(1, 0, 4'h0, 10'h005, 32'h0);          step();
        chk("a_read_deadbeef", ifc.a_rdata, 32'hDEAD_BEEF);
        idle_inputs(); step();

        // B byte write then B read
        drive_b(1, 1, 4'b0001, 10'h005, 32'h0000_00AA); step();
        drive_b(1, 0, 4'h0, 10'h005, 32'h0);             step();
        chk("b_read_merged", ifc.b_rdata, 32'hDEAD_BEAA);
        idle_inputs(); step();

        // Starvation: A continuous, B requesting from cycle 0
        first_b = -1;
        for (int c = 0; c < 12; c++) begin
            drive_a(1, 0, 4'h0, 10'h005, 32'h0);
            drive_b(1, 0, 4'h0, 10'h005, 32'h0);
            step();
            if (last_gb && first_b < 0) first_b = c;
        end
        chk("starve_first_grant", 32'(first_b), 32'd4);
        idle_inputs(); step();

        // Address wrap and simultaneous write
        drive_a(1, 1, 4'hF, 10'h000, 32'h0BAD_F00D); step();
        drive_a(1, 1, 4'hF, 10'h3FF, 32'hCAFE_F00D); step();
        wide_addr = 11'h3FF + 11'h001;
        drive_a(1, 0, 4'h0, wide_addr[AW-1:0], 32'h0); step();
        chk("wrap_read", ifc.a_rdata, 32'h0BAD_F00D);
        drive_a(1, 1, 4'hF, 10'h100, 32'h1111_AAAA);
        drive_b(1, 1, 4'hF, 10'h100, 32'h2222_BBBB); step();
        ifc.b_req = 0;
        drive_a(1, 0, 4'h0, 10'h100, 32'h0); step();
        chk("simul_write_a_wins", ifc.a_rdata, 32'h1111_AAAA);
        idle_inputs(); step();

        // Randomized traffic over a pool of initialised addresses
        for (int i = 0; i < 16; i++) begin
            pool[i] = AW'(i * 37 + 64);
            drive_a(1, 1, 4'hF, pool[i], $urandom);
            step();
        end
        idle_inputs();
        pa = 0; pb = 0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && ($urandom_range(0, 9) < 7)) begin
                pa = 1; wa = 1'($urandom); bea = 4'($urandom);
                ada = pool[$urandom_range(0, 15)]; wda = $urandom;
            end
            if (!pb && ($urandom_range(0, 9) < 6)) begin
                pb = 1; wb = 1'($urandom); beb = 4'($urandom);
                adb = pool[$urandom_range(0, 15)]; wdb = $urandom;
            end
            drive_a(pa, wa, bea, ada, wda);
            drive_b(pb, wb, beb, adb, wdb);
            step();
            if (last_ga) pa = 0;
            if (last_gb) pb = 0;
        end
        idle_inputs(); step();

`ifdef RISC_RAM_PARITY_EN
        // Parity: corrupt one stored bit, read it, then clean reads
        drive_a(1, 1, 4'hF, 10'h020, 32'h1234_5678); step();
        idle_inputs();
        dut.mem_q[10'h020] = dut.mem_q[10'h020] ^ 32'h0000_0001;
        mem_m[10'h020] = mem_m[10'h020] ^ 32'h0000_0001;
        bad_m[10'h020] = 4'b0001;
        drive_a(1, 0, 4'h0, 10'h020, 32'h0); step();
        chk("par_err_set", {31'b0, ifc.par_err}, 32'h1);
        drive_b(1, 0, 4'h0, pool[0], 32'h0); ifc.a_req = 0; step();
        drive_b(1, 0, 4'h0, pool[1], 32'h0); step();
        chk("par_err_sticky", {31'b0, ifc.par_err}, 32'h1);
        idle_inputs(); step();
        do_reset();
        chk("par_err_cleared", {31'b0, ifc.par_err}, 32'h0);
`else
        chk("par_err_tied", {31'b0, ifc.par_err}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
